// File: rtl/sc_reg_bank_if.sv
// Bus-side signal bundle for sc_reg_bank.
// master: drives the write request, write select/data, PC increment and error clear;
//         observes the packed register values, write acknowledge and error status.
// slave : the register bank side of the same signals.
interface sc_reg_bank_if #(
   parameter int unsigned DATAWIDTH_DECODER_OUT = 38,
   parameter int unsigned DATAWIDTH_BUS         = 32
);
   logic                                           SC_REG_BANK_WR_EN;
   logic [DATAWIDTH_DECODER_OUT-1:0]               SC_REG_BANK_WR_SEL;
   logic [DATAWIDTH_BUS-1:0]                       SC_REG_BANK_WR_DATA;
   logic                                           SC_REG_BANK_PC_INC;
   logic                                           SC_REG_BANK_CLR_ERR;
   logic [DATAWIDTH_DECODER_OUT*DATAWIDTH_BUS-1:0] SC_REG_BANK_REG_OUT;
   logic                                           SC_REG_BANK_WR_ACK;
   logic                                           SC_REG_BANK_WR_ERR;
   logic [7:0]                                     SC_REG_BANK_ERR_CNT;

   modport master (
      output SC_REG_BANK_WR_EN,
      output SC_REG_BANK_WR_SEL,
      output SC_REG_BANK_WR_DATA,
      output SC_REG_BANK_PC_INC,
      output SC_REG_BANK_CLR_ERR,
      input  SC_REG_BANK_REG_OUT,
      input  SC_REG_BANK_WR_ACK,
      input  SC_REG_BANK_WR_ERR,
      input  SC_REG_BANK_ERR_CNT
   );

   modport slave (
      input  SC_REG_BANK_WR_EN,
      input  SC_REG_BANK_WR_SEL,
      input  SC_REG_BANK_WR_DATA,
      input  SC_REG_BANK_PC_INC,
      input  SC_REG_BANK_CLR_ERR,
      output SC_REG_BANK_REG_OUT,
      output SC_REG_BANK_WR_ACK,
      output SC_REG_BANK_WR_ERR,
      output SC_REG_BANK_ERR_CNT
   );
endinterface

// File: rtl/sc_reg_bank.sv
// Register bank of the micro data path: DATAWIDTH_DECODER_OUT registers of DATAWIDTH_BUS
// bits, written through a one-hot select, all presented in parallel on REG_OUT.
// R0 reads as zero; R[PC_INDEX] can auto-increment by PC_STEP.
// Ports:
//   SC_REG_BANK_CLOCK_50     rising-edge system clock
//   SC_REG_BANK_RESET_InLow  asynchronous active-low reset
//   bus_io                   slave side of sc_reg_bank_if (write request, select, data,
//                            PC increment, error clear; register values, ack, error flag
//                            and saturating error count)
module sc_reg_bank #(
   parameter int unsigned DATAWIDTH_DECODER_OUT = 38,
   parameter int unsigned DATAWIDTH_BUS         = 32,
   parameter int unsigned PC_INDEX              = 32,
   parameter int unsigned PC_STEP               = 4
) (
   input logic          SC_REG_BANK_CLOCK_50,
   input logic          SC_REG_BANK_RESET_InLow,
   sc_reg_bank_if.slave bus_io
);

   localparam logic [DATAWIDTH_BUS-1:0] PcStep = DATAWIDTH_BUS'(PC_STEP);

   logic [DATAWIDTH_BUS-1:0] reg_q [DATAWIDTH_DECODER_OUT];
   logic [DATAWIDTH_BUS-1:0] reg_d [DATAWIDTH_DECODER_OUT];
   logic                     ack_q, ack_d;
   logic                     err_q, err_d;
   logic [7:0]               cnt_q, cnt_d;
   logic                     wr_legal, wr_illegal;

   always_comb begin
      wr_legal   = bus_io.SC_REG_BANK_WR_EN & $onehot(bus_io.SC_REG_BANK_WR_SEL);
      wr_illegal = bus_io.SC_REG_BANK_WR_EN & ~$onehot(bus_io.SC_REG_BANK_WR_SEL);

      for (int i = 0; i < int'(DATAWIDTH_DECODER_OUT); i++) begin
         reg_d[i] = reg_q[i];
      end

      // Increment first so a same-cycle write to the PC register overrides it.
      if (bus_io.SC_REG_BANK_PC_INC) begin
         reg_d[PC_INDEX] = reg_q[PC_INDEX] + PcStep;
      end

      if (wr_legal) begin
         for (int i = 1; i < int'(DATAWIDTH_DECODER_OUT); i++) begin
            if (bus_io.SC_REG_BANK_WR_SEL[i]) begin
               reg_d[i] = bus_io.SC_REG_BANK_WR_DATA;
            end
         end
      end

      // R0 is hardwired; its write is still acknowledged below.
      reg_d[0] = '0;

      ack_d = wr_legal;

      err_d = err_q;
      cnt_d = cnt_q;
      if (bus_io.SC_REG_BANK_CLR_ERR) begin
         err_d = 1'b0;
         cnt_d = '0;
      end
      // Applied after the clear so an error in the clearing cycle survives as a count of 1.
      if (wr_illegal) begin
         err_d = 1'b1;
         if (cnt_d != 8'hFF) begin
            cnt_d = cnt_d + 8'd1;
         end
      end
   end

   always_ff @(posedge SC_REG_BANK_CLOCK_50 or negedge SC_REG_BANK_RESET_InLow) begin
      if (!SC_REG_BANK_RESET_InLow) begin
         for (int i = 0; i < int'(DATAWIDTH_DECODER_OUT); i++) begin
            reg_q[i] <= '0;
         end
         ack_q <= 1'b0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < int'(DATAWIDTH_DECODER_OUT); i++) begin
            reg_q[i] <= reg_d[i];
         end
         ack_q <= ack_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   for (genvar g = 0; g < int'(DATAWIDTH_DECODER_OUT); g++) begin : g_reg_out
      assign bus_io.SC_REG_BANK_REG_OUT[g*DATAWIDTH_BUS +: DATAWIDTH_BUS] = reg_q[g];
   end

   assign bus_io.SC_REG_BANK_WR_ACK  = ack_q;
   assign bus_io.SC_REG_BANK_WR_ERR  = err_q;
   assign bus_io.SC_REG_BANK_ERR_CNT = cnt_q;

endmodule

// File: tb/tb_sc_reg_bank.sv
// Self-checking bench for sc_reg_bank: directed steps followed by random traffic, all
// compared against a behavioural model of the register file and error status.
module tb_sc_reg_bank;

   localparam int N  = 38;
   localparam int W  = 32;
   localparam int PC = 32;

   logic clk;
   logic rst_n;

   sc_reg_bank_if #(.DATAWIDTH_DECODER_OUT(N), .DATAWIDTH_BUS(W)) bus ();

   sc_reg_bank #(
      .DATAWIDTH_DECODER_OUT(N),
      .DATAWIDTH_BUS        (W),
      .PC_INDEX             (PC),
      .PC_STEP              (4)
   ) dut (
      .SC_REG_BANK_CLOCK_50   (clk),
      .SC_REG_BANK_RESET_InLow(rst_n),
      .bus_io                 (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [W-1:0] m_r [N];
   logic         m_ack;
   logic         m_err;
   int           m_cnt;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] dut_reg(input int i);
      logic [N*W-1:0] all;
      all = bus.SC_REG_BANK_REG_OUT;
      return all[i*W +: W];
   endfunction

   task automatic check_all(input string tag);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s R%0d", tag, i), dut_reg(i), m_r[i]);
      end
      chk({tag, " ack"}, W'(bus.SC_REG_BANK_WR_ACK), W'(m_ack));
      chk({tag, " err"}, W'(bus.SC_REG_BANK_WR_ERR), W'(m_err));
      chk({tag, " cnt"}, W'(bus.SC_REG_BANK_ERR_CNT), W'(m_cnt));
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_r[i] = '0;
      m_ack = 1'b0;
      m_err = 1'b0;
      m_cnt = 0;
   endtask

   // Applies the rules for one rising edge using the inputs currently driven.
   task automatic model_edge();
      int  ones;
      int  k;
      bit  legal;
      bit  illegal;
      ones = $countones(bus.SC_REG_BANK_WR_SEL);
      k = 0;
      for (int i = 0; i < N; i++) if (bus.SC_REG_BANK_WR_SEL[i]) k = i;
      legal   = bus.SC_REG_BANK_WR_EN && (ones == 1);
      illegal = bus.SC_REG_BANK_WR_EN && (ones != 1);
      if (bus.SC_REG_BANK_PC_INC && !(legal && k == PC)) m_r[PC] = m_r[PC] + 32'd4;
      if (legal && k != 0) m_r[k] = bus.SC_REG_BANK_WR_DATA;
      m_ack = legal;
      if (bus.SC_REG_BANK_CLR_ERR) begin
         m_err = 1'b0;
         m_cnt = 0;
      end
      if (illegal) begin
         m_err = 1'b1;
         m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
   endtask

   task automatic idle();
      bus.SC_REG_BANK_WR_EN   = 1'b0;
      bus.SC_REG_BANK_WR_SEL  = '0;
      bus.SC_REG_BANK_WR_DATA = '0;
      bus.SC_REG_BANK_PC_INC  = 1'b0;
      bus.SC_REG_BANK_CLR_ERR = 1'b0;
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic set_wr(input bit en, input logic [N-1:0] sel, input logic [W-1:0] data);
      bus.SC_REG_BANK_WR_EN   = en;
      bus.SC_REG_BANK_WR_SEL  = sel;
      bus.SC_REG_BANK_WR_DATA = data;
   endtask

   function automatic logic [N-1:0] bit_sel(input int k);
      logic [N-1:0] s;
      s = '0;
      s[k] = 1'b1;
      return s;
   endfunction

   initial begin
      logic [N-1:0] sel;
      idle();
      model_reset();
      rst_n = 1'b0;
      #2;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Write R5.
      set_wr(1'b1, bit_sel(5), 32'hDEADBEEF);
      cycle("wr_r5");
      chk("r5_const", dut_reg(5), 32'hDEADBEEF);
      chk("ack_r5_const", W'(bus.SC_REG_BANK_WR_ACK), 32'd1);
      idle();
      cycle("ack_drop");
      chk("ack_once", W'(bus.SC_REG_BANK_WR_ACK), 32'd0);

      // Write to R0 is acknowledged but discarded.
      set_wr(1'b1, bit_sel(0), 32'h12345678);
      cycle("wr_r0");
      chk("r0_zero", dut_reg(0), 32'h0);

      // Two illegal selects, then clear.
      set_wr(1'b1, '0, 32'hAAAA5555);
      cycle("illegal_zero");
      set_wr(1'b1, bit_sel(3) | bit_sel(7), 32'h5555AAAA);
      cycle("illegal_multi");
      chk("cnt_two", W'(bus.SC_REG_BANK_ERR_CNT), 32'd2);
      idle();
      bus.SC_REG_BANK_CLR_ERR = 1'b1;
      cycle("clr_err");
      chk("cnt_cleared", W'(bus.SC_REG_BANK_ERR_CNT), 32'd0);

      // Clear coinciding with an illegal write keeps the new error.
      set_wr(1'b1, '0, '0);
      cycle("err_before_clr");
      bus.SC_REG_BANK_CLR_ERR = 1'b1;
      cycle("clr_with_err");
      chk("cnt_one", W'(bus.SC_REG_BANK_ERR_CNT), 32'd1);
      idle();

      // PC wrap.
      set_wr(1'b1, bit_sel(PC), 32'hFFFFFFF8);
      cycle("wr_pc");
      idle();
      bus.SC_REG_BANK_PC_INC = 1'b1;
      cycle("pc_inc1");
      chk("pc_fffffffc", dut_reg(PC), 32'hFFFFFFFC);
      cycle("pc_inc2");
      chk("pc_wrap", dut_reg(PC), 32'h00000000);
      cycle("pc_inc3");
      chk("pc_4", dut_reg(PC), 32'h00000004);

      // Write to PC beats increment; write elsewhere does not block it.
      set_wr(1'b1, bit_sel(PC), 32'h100);
      cycle("pc_wr_wins");
      chk("pc_100", dut_reg(PC), 32'h100);
      set_wr(1'b1, bit_sel(7), 32'hCAFEF00D);
      cycle("pc_inc_r7");
      chk("pc_104", dut_reg(PC), 32'h104);
      chk("r7_written", dut_reg(7), 32'hCAFEF00D);
      idle();

      // Saturation.
      for (int i = 0; i < 300; i++) begin
         set_wr(1'b1, (i % 2 == 0) ? '0 : {N{1'b1}}, $urandom);
         cycle("sat");
      end
      chk("cnt_sat", W'(bus.SC_REG_BANK_ERR_CNT), 32'd255);
      idle();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0:       sel = '0;
            1:       sel = bit_sel($urandom_range(0, N - 1)) | bit_sel($urandom_range(0, N - 1));
            2:       sel = bit_sel(PC);
            default: sel = bit_sel($urandom_range(0, N - 1));
         endcase
         set_wr(1'($urandom_range(0, 3) != 0), sel, $urandom);
         bus.SC_REG_BANK_PC_INC  = 1'($urandom_range(0, 2) == 0);
         bus.SC_REG_BANK_CLR_ERR = 1'($urandom_range(0, 15) == 0);
         cycle("rand");
      end
      idle();

      // Asynchronous reset between edges.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_reset");
      chk("r7_after_rst", dut_reg(7), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sc_reg_bank.md
Name: sc_reg_bank

Overview:
- 38-entry x 32-bit register bank of the micro data path.
- Writes come from the data bus, addressed by the decoder's one-hot 38-bit write select.
- Drives all 38 register values in parallel to the one-hot read multiplexer that places one register on the bus.
- Also provides program-counter auto-increment and checks that the write select is legal one-hot.

Parameters:
- DATAWIDTH_DECODER_OUT, 38, number of registers; width of the one-hot write select.
- DATAWIDTH_BUS, 32, register and bus data width.
- PC_INDEX, 32, index of the register acting as program counter.
- PC_STEP, 4, increment added to the PC register on SC_REG_BANK_PC_INC.

Ports:
- SC_REG_BANK_CLOCK_50  in  1  system clock; all state updates on rising edge.
- SC_REG_BANK_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_REG_BANK_WR_EN  in  1  write request, sampled each rising edge.
- SC_REG_BANK_WR_SEL  in  DATAWIDTH_DECODER_OUT  one-hot write select from the decoder; bit i targets R[i].
- SC_REG_BANK_WR_DATA  in  DATAWIDTH_BUS  write data from the bus.
- SC_REG_BANK_PC_INC  in  1  increment request for R[PC_INDEX].
- SC_REG_BANK_CLR_ERR  in  1  clears the error flag and error count.
- SC_REG_BANK_REG_OUT  out  DATAWIDTH_DECODER_OUT*DATAWIDTH_BUS  packed register values; R[i] occupies bits [32i+31:32i].
- SC_REG_BANK_WR_ACK  out  1  registered one-cycle pulse after an accepted write.
- SC_REG_BANK_WR_ERR  out  1  sticky flag: an illegal write select was seen.
- SC_REG_BANK_ERR_CNT  out  8  saturating count of illegal write attempts.

Behaviour:
- Reset: RESET_InLow=0 asynchronously forces, regardless of clock:
  - all R[i]=0, REG_OUT=0
  - WR_ACK=0, WR_ERR=0, ERR_CNT=0
  - Asserting reset mid-operation aborts any write in progress; no partial update.
- Legal write: WR_EN=1 and WR_SEL has exactly one bit set (bit k) at a rising edge.
  - R[k] <= WR_DATA.
  - Value is visible on REG_OUT immediately after that edge (1-cycle write latency).
  - WR_ACK=1 for exactly the following cycle.
  - Back-to-back writes on consecutive edges are all accepted.
- R0 is hardwired to zero:
  - A legal write to R0 is acknowledged (WR_ACK pulses) but the data is discarded.
  - R0 always reads 0.
- Illegal write: WR_EN=1 and WR_SEL is zero or has more than one bit set.
  - No register changes; WR_ACK=0.
  - WR_ERR <= 1.
  - ERR_CNT <= ERR_CNT+1, saturating at 255.
- WR_EN=0: WR_SEL and WR_DATA are ignored; no error is recorded.
- PC increment: PC_INC=1 gives R[PC_INDEX] <= R[PC_INDEX]+PC_STEP modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000).
- PC_INC in the same cycle as a legal write to PC_INDEX: the write wins; the increment is dropped.
- PC_INC in the same cycle as a legal write to another register, or an illegal write: the increment still happens.
- CLR_ERR=1: WR_ERR <= 0, ERR_CNT <= 0.
- CLR_ERR in the same cycle as an illegal write: WR_ERR <= 1, ERR_CNT <= 1 (the new error is kept).
- Every output is driven directly by a register; no combinational path from inputs to outputs.

Test Plan:
- Reset, then write 0xDEADBEEF with WR_SEL=bit 5 -> next cycle R5=0xDEADBEEF, WR_ACK pulses once, all other registers 0.
- Write 0x12345678 with WR_SEL=bit 0 -> WR_ACK=1, R0 stays 0x00000000.
- WR_EN=1 with WR_SEL=0, then again with bits 3 and 7 set -> no registers change, WR_ERR=1, ERR_CNT=2; next cycle CLR_ERR=1 -> WR_ERR=0, ERR_CNT=0.
- Write R32=0xFFFFFFF8, then PC_INC for 3 cycles -> R32 reads 0xFFFFFFFC, 0x00000000, 0x00000004.
- PC_INC=1 together with a legal write of 0x100 to R32 -> R32=0x100. PC_INC=1 together with a write to R7 -> R32 increments by 4 and R7 is updated.
- 300 illegal writes -> ERR_CNT saturates at 255. Pulse RESET_InLow low between clock edges -> every register and all flags read 0 immediately, before the next edge.
